// File: rtl/gpr_pkg.sv
// Shared defaults and the address-width helper for the multi-port GPR file.
package gpr_pkg;

  localparam int unsigned GPR_XLEN   = 32;
  localparam int unsigned GPR_NUM    = 32;
  localparam int unsigned GPR_NUM_RP = 2;

  // Smallest w with 2**w >= n; used to size register addresses.
  function automatic int unsigned calc_aw(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard: writes clear, issues set, issue wins on a tie, x0 never busy.
// Exposes the post-update vector so read ports can bypass same-cycle changes.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter  int unsigned NUM_GPR = GPR_NUM,
  localparam int unsigned AW      = calc_aw(NUM_GPR)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_wp0_we,
  input  logic [AW-1:0]      i_wp0_addr,
  input  logic               i_wp1_we,
  input  logic [AW-1:0]      i_wp1_addr,
  input  logic               i_iss_we,
  input  logic [AW-1:0]      i_iss_addr,
  output logic [NUM_GPR-1:0] o_busy_next
);

  logic [NUM_GPR-1:0] busy_q, busy_d;

  // Next busy vector: clears from writebacks first so a same-cycle issue overrides them.
  always_comb begin
    busy_d = busy_q;
    if (i_wp0_we) busy_d[i_wp0_addr] = 1'b0;
    if (i_wp1_we) busy_d[i_wp1_addr] = 1'b0;
    if (i_iss_we) busy_d[i_iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign o_busy_next = busy_d;

endmodule

// File: rtl/gpr_mp.sv
// Flip-flop register file with two write ports, NUM_RP registered read ports,
// write-first bypass of data and busy, and x0 hardwired to zero.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter  int unsigned XLEN    = GPR_XLEN,
  parameter  int unsigned NUM_GPR = GPR_NUM,
  parameter  int unsigned NUM_RP  = GPR_NUM_RP,
  localparam int unsigned AW      = calc_aw(NUM_GPR)
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic                   i_wp0_we,
  input  logic [AW-1:0]          i_wp0_addr,
  input  logic [XLEN-1:0]        i_wp0_data,
  input  logic                   i_wp1_we,
  input  logic [AW-1:0]          i_wp1_addr,
  input  logic [XLEN-1:0]        i_wp1_data,
  input  logic                   i_iss_we,
  input  logic [AW-1:0]          i_iss_addr,
  input  logic [NUM_RP-1:0]      i_rs_re,
  input  logic [NUM_RP*AW-1:0]   i_rs_addr,
  output logic [NUM_RP*XLEN-1:0] o_rs_data,
  output logic [NUM_RP-1:0]      o_rs_busy
);

  logic [XLEN-1:0]        reg_q [NUM_GPR];
  logic [XLEN-1:0]        reg_d [NUM_GPR];
  logic [NUM_GPR-1:0]     busy_d;
  logic [NUM_RP*XLEN-1:0] rs_data_q;
  logic [NUM_RP-1:0]      rs_busy_q;

  gpr_scoreboard #(
    .NUM_GPR (NUM_GPR)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_wp0_we    (i_wp0_we),
    .i_wp0_addr  (i_wp0_addr),
    .i_wp1_we    (i_wp1_we),
    .i_wp1_addr  (i_wp1_addr),
    .i_iss_we    (i_iss_we),
    .i_iss_addr  (i_iss_addr),
    .o_busy_next (busy_d)
  );

  // Next register contents: port 1 applied last so it wins an address collision.
  always_comb begin
    reg_d = reg_q;
    if (i_wp0_we) reg_d[i_wp0_addr] = i_wp0_data;
    if (i_wp1_we) reg_d[i_wp1_addr] = i_wp1_data;
    reg_d[0] = '0;
  end

  // Register storage; flops rather than RAM because reset clears every entry.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < NUM_GPR; i++) reg_q[i] <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  // Read ports sample post-update state (write-first bypass); idle ports hold.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rs_data_q <= '0;
      rs_busy_q <= '0;
    end else begin
      for (int k = 0; k < NUM_RP; k++) begin
        if (i_rs_re[k]) begin
          rs_data_q[k*XLEN +: XLEN] <= reg_d[i_rs_addr[k*AW +: AW]];
          rs_busy_q[k]              <= busy_d[i_rs_addr[k*AW +: AW]];
        end
      end
    end
  end

  assign o_rs_data = rs_data_q;
  assign o_rs_busy = rs_busy_q;

endmodule

// File: tb/tb_gpr_mp.sv
// Self-checking bench for gpr_mp: directed scenarios plus randomized traffic
// checked against an architectural model of the register file.
module tb_gpr_mp;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_GPR = 32;
  localparam int unsigned NUM_RP  = 2;
  localparam int unsigned AW      = 5;

  logic                   i_clk;
  logic                   i_nrst;
  logic                   i_wp0_we;
  logic [AW-1:0]          i_wp0_addr;
  logic [XLEN-1:0]        i_wp0_data;
  logic                   i_wp1_we;
  logic [AW-1:0]          i_wp1_addr;
  logic [XLEN-1:0]        i_wp1_data;
  logic                   i_iss_we;
  logic [AW-1:0]          i_iss_addr;
  logic [NUM_RP-1:0]      i_rs_re;
  logic [NUM_RP*AW-1:0]   i_rs_addr;
  logic [NUM_RP*XLEN-1:0] o_rs_data;
  logic [NUM_RP-1:0]      o_rs_busy;

  int n_pass;
  int n_total;

  // Architectural model: register values, busy flags, and expected port outputs.
  logic [XLEN-1:0] m_reg  [NUM_GPR];
  bit              m_busy [NUM_GPR];
  logic [XLEN-1:0] m_data [NUM_RP];
  bit              m_rbsy [NUM_RP];

  gpr_mp #(
    .XLEN    (XLEN),
    .NUM_GPR (NUM_GPR),
    .NUM_RP  (NUM_RP)
  ) dut (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_wp0_we   (i_wp0_we),
    .i_wp0_addr (i_wp0_addr),
    .i_wp0_data (i_wp0_data),
    .i_wp1_we   (i_wp1_we),
    .i_wp1_addr (i_wp1_addr),
    .i_wp1_data (i_wp1_data),
    .i_iss_we   (i_iss_we),
    .i_iss_addr (i_iss_addr),
    .i_rs_re    (i_rs_re),
    .i_rs_addr  (i_rs_addr),
    .o_rs_data  (o_rs_data),
    .o_rs_busy  (o_rs_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    for (int i = 0; i < NUM_GPR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    for (int k = 0; k < NUM_RP; k++) begin
      m_data[k] = '0;
      m_rbsy[k] = 1'b0;
    end
  endfunction

  // One clock edge of architectural behaviour: writes land, busy updates, then reads
  // observe the updated state.
  function automatic void model_step();
    int a;
    if (!i_nrst) begin
      model_reset();
      return;
    end
    if (i_wp0_we && i_wp0_addr != 0) begin
      m_reg[i_wp0_addr]  = i_wp0_data;
      m_busy[i_wp0_addr] = 1'b0;
    end
    if (i_wp1_we && i_wp1_addr != 0) begin
      m_reg[i_wp1_addr]  = i_wp1_data;
      m_busy[i_wp1_addr] = 1'b0;
    end
    if (i_iss_we && i_iss_addr != 0) m_busy[i_iss_addr] = 1'b1;
    for (int k = 0; k < NUM_RP; k++) begin
      if (i_rs_re[k]) begin
        a = int'(i_rs_addr[k*AW +: AW]);
        m_data[k] = m_reg[a];
        m_rbsy[k] = m_busy[a];
      end
    end
  endfunction

  task automatic idle();
    i_wp0_we = 0; i_wp0_addr = '0; i_wp0_data = '0;
    i_wp1_we = 0; i_wp1_addr = '0; i_wp1_data = '0;
    i_iss_we = 0; i_iss_addr = '0;
    i_rs_re  = '0; i_rs_addr = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    idle();
    i_nrst = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    n_total++;
    if (o_rs_data !== '0 || o_rs_busy !== '0)
      $display("FAIL reset_outputs data=%h busy=%b want 0/0", o_rs_data, o_rs_busy);
    else n_pass++;
    i_nrst = 1'b1;
    for (int a = 0; a < NUM_GPR; a++) begin
      i_rs_re = '1;
      for (int k = 0; k < NUM_RP; k++) i_rs_addr[k*AW +: AW] = AW'(a);
      tick();
      for (int k = 0; k < NUM_RP; k++) begin
        n_total++;
        if (o_rs_data[k*XLEN +: XLEN] !== '0 || o_rs_busy[k] !== 1'b0)
          $display("FAIL reset_read x%0d port%0d data=%h busy=%b want 0/0", a, k,
                   o_rs_data[k*XLEN +: XLEN], o_rs_busy[k]);
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    i_wp0_we = 1; i_wp0_addr = 5; i_wp0_data = 32'hDEADBEEF;
    tick();
    idle();
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 5;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'hDEADBEEF)
      $display("FAIL read_x5 got=%h want=deadbeef", o_rs_data[0 +: XLEN]);
    else n_pass++;
    idle();
    i_wp0_we = 1; i_wp0_addr = 0; i_wp0_data = 32'h1234;
    tick();
    idle();
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 0;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h0)
      $display("FAIL read_x0 got=%h want=0", o_rs_data[0 +: XLEN]);
    else n_pass++;
    idle();
  endtask

  task automatic test_dual_write();
    idle();
    i_wp0_we = 1; i_wp0_addr = 7; i_wp0_data = 32'h11;
    i_wp1_we = 1; i_wp1_addr = 7; i_wp1_data = 32'h22;
    i_rs_re[1] = 1; i_rs_addr[AW +: AW] = 7;
    tick();
    n_total++;
    if (o_rs_data[XLEN +: XLEN] !== 32'h22 || o_rs_busy[1] !== 1'b0)
      $display("FAIL dual_bypass got=%h/%b want=22/0", o_rs_data[XLEN +: XLEN], o_rs_busy[1]);
    else n_pass++;
    idle();
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 7;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h22)
      $display("FAIL dual_later got=%h want=22", o_rs_data[0 +: XLEN]);
    else n_pass++;
    idle();
  endtask

  task automatic test_issue();
    idle();
    i_iss_we = 1; i_iss_addr = 9;
    tick();
    idle();
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 9;
    tick();
    n_total++;
    if (o_rs_busy[0] !== 1'b1)
      $display("FAIL issue_busy got=%b want=1", o_rs_busy[0]);
    else n_pass++;
    idle();
    i_wp1_we = 1; i_wp1_addr = 9; i_wp1_data = 32'h5;
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 9;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h5 || o_rs_busy[0] !== 1'b0)
      $display("FAIL wb_bypass got=%h/%b want=5/0", o_rs_data[0 +: XLEN], o_rs_busy[0]);
    else n_pass++;
    // With reads disabled and x9 rewritten, both ports must hold their last values.
    idle();
    i_wp0_we = 1; i_wp0_addr = 9; i_wp0_data = 32'h99;
    i_iss_we = 1; i_iss_addr = 9;
    i_rs_addr[0 +: AW] = 9;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h5 || o_rs_busy[0] !== 1'b0 ||
        o_rs_data[XLEN +: XLEN] !== 32'h22)
      $display("FAIL hold got=%h/%b/%h want=5/0/22", o_rs_data[0 +: XLEN], o_rs_busy[0],
               o_rs_data[XLEN +: XLEN]);
    else n_pass++;
    idle();
  endtask

  task automatic test_issue_write();
    idle();
    i_iss_we = 1; i_iss_addr = 3;
    i_wp0_we = 1; i_wp0_addr = 3; i_wp0_data = 32'h7;
    tick();
    idle();
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 3;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h7 || o_rs_busy[0] !== 1'b1)
      $display("FAIL issue_wins got=%h/%b want=7/1", o_rs_data[0 +: XLEN], o_rs_busy[0]);
    else n_pass++;
    idle();
    i_iss_we = 1; i_iss_addr = 0;
    tick();
    idle();
    i_rs_re[1] = 1; i_rs_addr[AW +: AW] = 0;
    tick();
    n_total++;
    if (o_rs_data[XLEN +: XLEN] !== 32'h0 || o_rs_busy[1] !== 1'b0)
      $display("FAIL issue_x0 got=%h/%b want=0/0", o_rs_data[XLEN +: XLEN], o_rs_busy[1]);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_midcycle();
    idle();
    i_wp0_we = 1; i_wp0_addr = 4; i_wp0_data = 32'hAA;
    tick();
    idle();
    i_rs_re = '1;
    i_rs_addr[0 +: AW] = 4; i_rs_addr[AW +: AW] = 4;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'hAA)
      $display("FAIL pre_reset got=%h want=aa", o_rs_data[0 +: XLEN]);
    else n_pass++;
    #2;
    i_nrst = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (o_rs_data !== '0 || o_rs_busy !== '0)
      $display("FAIL async_reset data=%h busy=%b want 0/0", o_rs_data, o_rs_busy);
    else n_pass++;
    // Operations presented while reset is held must be ignored.
    i_wp1_we = 1; i_wp1_addr = 4; i_wp1_data = 32'h55;
    i_iss_we = 1; i_iss_addr = 4;
    tick();
    n_total++;
    if (o_rs_data !== '0 || o_rs_busy !== '0)
      $display("FAIL held_reset data=%h busy=%b want 0/0", o_rs_data, o_rs_busy);
    else n_pass++;
    idle();
    i_nrst = 1'b1;
    i_rs_re[0] = 1; i_rs_addr[0 +: AW] = 4;
    tick();
    n_total++;
    if (o_rs_data[0 +: XLEN] !== 32'h0 || o_rs_busy[0] !== 1'b0)
      $display("FAIL post_reset got=%h/%b want=0/0", o_rs_data[0 +: XLEN], o_rs_busy[0]);
    else n_pass++;
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      // Narrow address range so collisions, bypasses and x0 hits are frequent.
      i_wp0_we   = 1'($urandom_range(0, 1));
      i_wp0_addr = AW'($urandom_range(0, 7));
      i_wp0_data = $urandom;
      i_wp1_we   = 1'($urandom_range(0, 1));
      i_wp1_addr = AW'($urandom_range(0, 7));
      i_wp1_data = $urandom;
      i_iss_we   = 1'($urandom_range(0, 1));
      i_iss_addr = AW'($urandom_range(0, 7));
      i_rs_re    = NUM_RP'($urandom);
      for (int k = 0; k < NUM_RP; k++) i_rs_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      tick();
      for (int k = 0; k < NUM_RP; k++) begin
        n_total++;
        if (o_rs_data[k*XLEN +: XLEN] !== m_data[k] || o_rs_busy[k] !== m_rbsy[k])
          $display("FAIL random c%0d port%0d got=%h/%b want=%h/%b", n, k,
                   o_rs_data[k*XLEN +: XLEN], o_rs_busy[k], m_data[k], m_rbsy[k]);
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_nrst  = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_dual_write();
    test_issue();
    test_issue_write();
    test_reset_midcycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpr_mp.md
GPR_MP -- requirements
Module: gpr_mp

Interface
REQ-001 Parameter XLEN, default 32, data width per register.
REQ-002 Parameter NUM_GPR, default 32, register count; power of two, >=2.
REQ-003 Parameter NUM_RP, default 2, read port count, 1..4.
REQ-004 Derived AW = log2(NUM_GPR), address width; not overridable.
REQ-005 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-006 i_nrst  in  1  reset, asynchronous, active-low.
REQ-007 i_wp0_we / i_wp1_we  in  1 each  write enables, ports 0 and 1.
REQ-008 i_wp0_addr / i_wp1_addr  in  AW each  write addresses.
REQ-009 i_wp0_data / i_wp1_data  in  XLEN each  write data.
REQ-010 i_iss_we  in  1  issue strobe: mark destination register busy.
REQ-011 i_iss_addr  in  AW  destination register being issued.
REQ-012 i_rs_re  in  NUM_RP  per-port read enable, bit k = port k.
REQ-013 i_rs_addr  in  NUM_RP*AW  read addresses, slice k = port k.
REQ-014 o_rs_data  out  NUM_RP*XLEN  registered read data, slice k = port k.
REQ-015 o_rs_busy  out  NUM_RP  registered busy flag of register read on port k.

Function
REQ-016 Register 0 SHALL always read zero and never be busy; writes and issues to address 0 SHALL be ignored.
REQ-017 Writes SHALL take effect at the rising edge where the port's we=1 and addr!=0.
REQ-018 When both write ports target the same nonzero address in one cycle, port 1 data SHALL be stored and port 0 discarded.
REQ-019 Reads SHALL have latency 1: with re=1 at edge N, o_rs_data/o_rs_busy SHALL hold the result after edge N.
REQ-020 With re=0, port k's o_rs_data and o_rs_busy SHALL hold their previous values.
REQ-021 Read of an address being written in the same cycle SHALL return the new data (write-first bypass), using port 1 data if both ports write it.
REQ-022 A write to register r SHALL clear busy[r]; i_iss_we SHALL set busy[i_iss_addr].
REQ-023 Issue and write to the same register in one cycle SHALL leave busy set (issue wins).
REQ-024 o_rs_busy SHALL reflect busy after the same-cycle write/issue update (bypassed like data).
REQ-025 Out-of-range addresses cannot occur (NUM_GPR power of two); no error output.

Reset
REQ-026 i_nrst=0 SHALL immediately clear all registers, all busy bits, o_rs_data and o_rs_busy to 0, regardless of clock.
REQ-027 While i_nrst=0, writes, issues and reads SHALL be ignored; an operation in flight at assertion SHALL be lost.
REQ-028 Deassertion is externally synchronised; the first edge with i_nrst=1 SHALL process inputs normally.

Structure
REQ-029 Package gpr_pkg SHALL hold default XLEN, NUM_GPR, NUM_RP and the AW derivation function.
REQ-030 Busy bit-vector with set/clear/priority logic SHALL be a sub-module gpr_scoreboard instantiated once.
REQ-031 Storage SHALL be flip-flops, not inferred RAM, since reset clears all entries.

Verification
REQ-032 Reset, then re on all ports addr 0..NUM_GPR-1 -> all data 0, all busy 0.
REQ-033 wp0 writes x5=0xDEADBEEF, next cycle rs0 reads x5 -> 0xDEADBEEF one edge later; write x0=0x1234 -> x0 reads 0.
REQ-034 Same cycle wp0 x7=0x11, wp1 x7=0x22, rs1 reads x7 -> rs1 data 0x22 (bypass), and later read of x7 returns 0x22.
REQ-035 Issue x9, next cycle read x9 -> busy 1; wp1 writes x9=0x5 with rs0 reading x9 same cycle -> data 0x5, busy 0.
REQ-036 Same cycle issue x3 and wp0 writes x3=0x7 -> subsequent read x3: data 0x7, busy 1; issue x0 -> read x0 busy 0.
REQ-037 Write x4=0xAA, assert i_nrst mid-cycle between edges -> o_rs_data 0 immediately; after release x4 reads 0.
